// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port data memory.
// Converts per-port req/ack handshakes into one-cycle MemRd/MemWr strobes and returns read data.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic              last_grant_q;   // 1 = B was granted last
  logic              owner_q;
  logic              we_q;
  logic              in_range_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic              a_err_q;
  logic              b_err_q;
  logic              busy_q;

  logic              grant_b_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;
  logic              sel_we_d;
  logic              in_range_d;

  always_comb begin
    grant_b_d = 1'b0;
    if (a_req && b_req) begin
      grant_b_d = ~last_grant_q;
    end else if (b_req) begin
      grant_b_d = 1'b1;
    end
    sel_addr_d  = grant_b_d ? b_addr  : a_addr;
    sel_wdata_d = grant_b_d ? b_wdata : a_wdata;
    sel_we_d    = grant_b_d ? b_we    : a_we;
    in_range_d  = ({1'b0, sel_addr_d} < DEPTH_X);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      in_range_q   <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            owner_q      <= grant_b_d;
            last_grant_q <= grant_b_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            we_q         <= sel_we_d;
            in_range_q   <= in_range_d;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (!in_range_q || we_q) begin
            // Acks are registered, so they are raised on the transition into ACK.
            if (!in_range_q) begin
              rdata_q <= '0;
            end
            a_ack_q <= ~owner_q;
            b_ack_q <= owner_q;
            a_err_q <= ~owner_q & ~in_range_q;
            b_err_q <= owner_q & ~in_range_q;
            state_q <= ACK;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          rdata_q <= mem_data_out;
          a_ack_q <= ~owner_q;
          b_ack_q <= owner_q;
          state_q <= ACK;
        end
        ACK: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded from the registered state and suppressed during reset.
  assign mem_rd      = (state_q == ISSUE) && !we_q && in_range_q && !reset;
  assign mem_wr      = (state_q == ISSUE) &&  we_q && in_range_q && !reset;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign rdata       = rdata_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_err       = a_err_q;
  assign b_err       = b_err_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized single/dual-port traffic checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_data_out;
  logic          busy, owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_err(b_err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
    .busy(busy), .owner(owner)
  );

  // Single-port memory with one-cycle registered read, preloaded with mem[i] = i.
  logic [DW-1:0] mem [DEPTH];
  logic          preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
    end else begin
      if (mem_wr && mem_addr < AW'(DEPTH)) mem[mem_addr[9:0]] <= mem_data_in;
      if (mem_rd) mem_data_out <= mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe invariants, checked whenever a strobe is visible.
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      chk("strobe_exclusive", 64'(mem_rd & mem_wr), 64'd0);
      chk("strobe_while_busy", 64'(busy), 64'd1);
    end
  end

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          port;
    int          cyc;
    bit          err;
    bit          own;
    logic [31:0] rdata;
  } ack_t;

  typedef struct {
    int          cyc;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  ack_t    obs_acks[$], exp_acks[$];
  strobe_t obs_str[$],  exp_str[$];

  // Reference state: memory contents, last granted port (1 = B), current rdata.
  logic [31:0] ref_mem [DEPTH];
  bit          m_last;
  logic [31:0] m_rdata;

  // Transaction-level model: order by round-robin, timing from the latency rules
  // (read ack 3 cycles after the sampling IDLE cycle, write/out-of-range 2, one IDLE between).
  task automatic model_pair(input bit ua, input bit ub, input txn_t ta, input txn_t tb);
    int   start;
    int   lat;
    bit   oor;
    bit   order[$];
    txn_t t;
    exp_acks.delete();
    exp_str.delete();
    start = 0;
    if (ua && ub) begin
      if (m_last) order = '{1'b0, 1'b1};
      else        order = '{1'b1, 1'b0};
    end else if (ua) order = '{1'b0};
    else if (ub)     order = '{1'b1};
    foreach (order[i]) begin
      t   = order[i] ? tb : ta;
      oor = (t.addr >= DEPTH);
      lat = (oor || t.we) ? 2 : 3;
      if (!oor) exp_str.push_back('{start + 1, !t.we, t.we, t.addr, t.we ? t.wdata : 32'd0});
      if (oor)        m_rdata = 32'd0;
      else if (t.we)  ref_mem[t.addr[9:0]] = t.wdata;
      else            m_rdata = ref_mem[t.addr[9:0]];
      exp_acks.push_back('{order[i], start + lat, oor, order[i], m_rdata});
      m_last = order[i];
      start  = start + lat + 1;
    end
  endtask

  // Call with the DUT idle at a negedge; returns idle at a negedge.
  task automatic run_reqs(input bit ua, input bit ub, input txn_t ta, input txn_t tb);
    bit pa, pb;
    obs_acks.delete();
    obs_str.delete();
    a_req = ua; a_we = ta.we; a_addr = ta.addr; a_wdata = ta.wdata;
    b_req = ub; b_we = tb.we; b_addr = tb.addr; b_wdata = tb.wdata;
    pa = ua; pb = ub;
    for (int n = 1; n <= 30 && (pa || pb); n++) begin
      @(negedge clk);
      if (mem_rd || mem_wr)
        obs_str.push_back('{n, mem_rd, mem_wr, mem_addr, mem_wr ? mem_data_in : 32'd0});
      if (a_ack) begin obs_acks.push_back('{1'b0, n, a_err, owner, rdata}); a_req = 1'b0; pa = 1'b0; end
      if (b_ack) begin obs_acks.push_back('{1'b1, n, b_err, owner, rdata}); b_req = 1'b0; pb = 1'b0; end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    for (int n = 0; n < 10 && busy; n++) @(negedge clk);
  endtask

  task automatic check_run(input string tag);
    int na, ns;
    chk({tag, ".nacks"}, 64'(obs_acks.size()), 64'(exp_acks.size()));
    na = (obs_acks.size() < exp_acks.size()) ? obs_acks.size() : exp_acks.size();
    for (int i = 0; i < na; i++) begin
      chk({tag, ".port"},  64'(obs_acks[i].port),  64'(exp_acks[i].port));
      chk({tag, ".cyc"},   64'(obs_acks[i].cyc),   64'(exp_acks[i].cyc));
      chk({tag, ".err"},   64'(obs_acks[i].err),   64'(exp_acks[i].err));
      chk({tag, ".owner"}, 64'(obs_acks[i].own),   64'(exp_acks[i].own));
      chk({tag, ".rdata"}, 64'(obs_acks[i].rdata), 64'(exp_acks[i].rdata));
    end
    chk({tag, ".nstrobes"}, 64'(obs_str.size()), 64'(exp_str.size()));
    ns = (obs_str.size() < exp_str.size()) ? obs_str.size() : exp_str.size();
    for (int i = 0; i < ns; i++) begin
      chk({tag, ".str_cyc"},  64'(obs_str[i].cyc),  64'(exp_str[i].cyc));
      chk({tag, ".str_rw"},   64'({obs_str[i].rd, obs_str[i].wr}), 64'({exp_str[i].rd, exp_str[i].wr}));
      chk({tag, ".str_addr"}, 64'(obs_str[i].addr), 64'(exp_str[i].addr));
      chk({tag, ".str_data"}, 64'(obs_str[i].data), 64'(exp_str[i].data));
    end
  endtask

  task automatic do_reset();
    a_req = 1'b0; b_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last  = 1'b1;
    m_rdata = 32'd0;
  endtask

  // Hold requests (A reads 1, B reads 2) and expect an ack every 4 cycles;
  // grants alternate starting with A when both are held straight after reset.
  task automatic hold_seq(input bit ua, input bit ub, input int nacks, input string tag);
    int got;
    bit eb;
    got = 0;
    a_req = ua; a_we = 1'b0; a_addr = 32'd1; a_wdata = 32'd0;
    b_req = ub; b_we = 1'b0; b_addr = 32'd2; b_wdata = 32'd0;
    for (int n = 1; n <= nacks * 4 + 8 && got < nacks; n++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        eb = (ua && ub) ? got[0] : ub;
        chk({tag, ".b_ack"}, 64'(b_ack), 64'(eb));
        chk({tag, ".a_ack"}, 64'(a_ack), 64'(!eb));
        chk({tag, ".cyc"},   64'(n), 64'(3 + 4 * got));
        chk({tag, ".rdata"}, 64'(rdata), eb ? 64'd2 : 64'd1);
        got++;
      end
    end
    chk({tag, ".count"}, 64'(got), 64'(nacks));
    a_req = 1'b0;
    b_req = 1'b0;
    for (int n = 0; n < 10 && busy; n++) @(negedge clk);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       t.addr = 32'd1024 + $urandom_range(0, 4096);
      1:       t.addr = 32'hFFFF_FFFF;
      2, 3, 4: t.addr = $urandom_range(0, 15);
      default: t.addr = $urandom_range(0, 1023);
    endcase
    t.wdata = $urandom();
    return t;
  endfunction

  vec_t vecs[12];

  initial begin
    txn_t t, t2;
    bit   ua, ub;
    int   k;
    bit   seen;

    vecs[0]  = '{1'b0, 1'b0, 32'd5,         32'd0,         3, 1'b0, 32'd5};
    vecs[1]  = '{1'b1, 1'b1, 32'd10,        32'hDEADBEEF,  2, 1'b0, 32'd5};
    vecs[2]  = '{1'b1, 1'b0, 32'd10,        32'd0,         3, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'd1024,      32'd0,         2, 1'b1, 32'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'd1023,      32'h1234,      2, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'd1023,      32'd0,         3, 1'b0, 32'h1234};
    vecs[6]  = '{1'b1, 1'b0, 32'd0,         32'd0,         3, 1'b0, 32'd0};
    vecs[7]  = '{1'b1, 1'b0, 32'hFFFFFFFF,  32'd0,         2, 1'b1, 32'd0};
    vecs[8]  = '{1'b1, 1'b1, 32'd2048,      32'h55,        2, 1'b1, 32'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'd1023,      32'd0,         3, 1'b0, 32'h1234};
    vecs[10] = '{1'b0, 1'b1, 32'd3,         32'hA5A5A5A5,  2, 1'b0, 32'h1234};
    vecs[11] = '{1'b1, 1'b0, 32'd3,         32'd0,         3, 1'b0, 32'hA5A5A5A5};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    reset = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    do_reset();

    chk("rst.busy",  64'(busy), 64'd0);
    chk("rst.acks",  64'({a_ack, b_ack, a_err, b_err}), 64'd0);
    chk("rst.rdata", 64'(rdata), 64'd0);
    chk("rst.owner", 64'(owner), 64'd0);
    chk("rst.strb",  64'({mem_rd, mem_wr}), 64'd0);
    chk("rst.addr",  64'(mem_addr), 64'd0);

    // Directed vectors, single port each.
    foreach (vecs[i]) begin
      t = '{vecs[i].we, vecs[i].addr, vecs[i].wdata};
      model_pair(!vecs[i].port, vecs[i].port, t, t);
      run_reqs(!vecs[i].port, vecs[i].port, t, t);
      chk("vec.nacks", 64'(obs_acks.size()), 64'd1);
      if (obs_acks.size() > 0) begin
        chk("vec.port",  64'(obs_acks[0].port),  64'(vecs[i].port));
        chk("vec.lat",   64'(obs_acks[0].cyc),   64'(vecs[i].lat));
        chk("vec.err",   64'(obs_acks[0].err),   64'(vecs[i].err));
        chk("vec.rdata", 64'(obs_acks[0].rdata), 64'(vecs[i].rdata));
      end
      chk("vec.nstrobes", 64'(obs_str.size()), vecs[i].err ? 64'd0 : 64'd1);
      if (obs_str.size() > 0) chk("vec.str_addr", 64'(obs_str[0].addr), 64'(vecs[i].addr));
      check_run("vec_model");
    end

    // Both requesting straight after reset: A, B, A, B.
    do_reset();
    hold_seq(1'b1, 1'b1, 4, "both_held");

    // Continuous A reads with B idle: one per 4 cycles.
    hold_seq(1'b1, 1'b0, 5, "a_held");

    // Reset while in WAIT: no ack, strobes low, held request re-arbitrated.
    do_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
    @(negedge clk);
    chk("rstwait.issue_rd", 64'(mem_rd), 64'd1);
    @(negedge clk);
    chk("rstwait.busy_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstwait.busy", 64'(busy), 64'd0);
    chk("rstwait.ack",  64'({a_ack, b_ack}), 64'd0);
    chk("rstwait.strb", 64'({mem_rd, mem_wr}), 64'd0);
    reset = 1'b0;
    k = 0; seen = 1'b0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge clk);
      if (a_ack) begin k = n; seen = 1'b1; end
    end
    chk("rstwait.relat", 64'(k), 64'd3);
    chk("rstwait.rdata", 64'(rdata), 64'd7);
    chk("rstwait.err",   64'(a_err), 64'd0);
    a_req = 1'b0;
    for (int n = 0; n < 10 && busy; n++) @(negedge clk);

    // Reset asserted during ISSUE gates the strobe in that same cycle.
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd9; a_wdata = 32'h77;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstissue.gate", 64'({mem_rd, mem_wr}), 64'd0);
    a_req = 1'b0;
    @(negedge clk);
    chk("rstissue.busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstissue.no_ack", 64'({a_ack, b_ack}), 64'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int it = 0; it < 200; it++) begin
      ua = 1'($urandom_range(0, 1));
      ub = 1'($urandom_range(0, 1));
      if (!ua && !ub) ua = 1'b1;
      t  = rand_txn();
      t2 = rand_txn();
      model_pair(ua, ub, t, t2);
      run_reqs(ua, ub, t, t2);
      check_run("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
